if_ex_skid_stage: RTL and testbench

Parametrised, elastic IF→EX stage register for the pipelined core. It replaces a plain flop stage with a two-entry skid buffer and valid/ready handshakes on both sides. The buffer absorbs one beat of back-pressure without a combinational ready path, holds under stall instead of discarding, and inserts a NOP bubble on flush (taken branch). It sits between fetch (PC/instruction memory) and execute, and exports a saturating stall-cycle counter for performance monitoring.

---
 rtl/if_ex_skid_stage.sv | 134 +++++++++++++
 tb/tb_if_ex_skid_stage.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_ex_skid_stage.sv
// Elastic IF->EX stage: two-entry skid buffer with registered ready,
// NOP bubble on flush and a saturating back-pressure cycle counter.
module if_ex_skid_stage #(
    parameter int          PC_W      = 32,
    parameter int          INSTR_W   = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CNT_W-1:0]   stall_cycles
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    occ_e               state_q, state_d;
    logic [PC_W-1:0]    m_pc_q, m_pc_d;
    logic [INSTR_W-1:0] m_instr_q, m_instr_d;
    logic [PC_W-1:0]    s_pc_q, s_pc_d;
    logic [INSTR_W-1:0] s_instr_q, s_instr_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic accept;
    logic drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d   = state_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    m_pc_d    = in_pc;
                    m_instr_d = in_instr;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (drain && accept) begin
                    m_pc_d    = in_pc;
                    m_instr_d = in_instr;
                end else if (drain) begin
                    m_pc_d    = '0;
                    m_instr_d = NOP_W;
                    state_d   = EMPTY;
                end else if (accept) begin
                    s_pc_d    = in_pc;
                    s_instr_d = in_instr;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (drain) begin
                    m_pc_d    = s_pc_q;
                    m_instr_d = s_instr_q;
                    s_pc_d    = '0;
                    s_instr_d = NOP_W;
                    state_d   = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush overrides whatever the handshakes did this cycle.
        if (flush) begin
            state_d   = EMPTY;
            m_pc_d    = '0;
            m_instr_d = NOP_W;
            s_pc_d    = '0;
            s_instr_d = NOP_W;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid_q && !out_ready && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            m_pc_q      <= '0;
            m_instr_q   <= NOP_W;
            s_pc_q      <= '0;
            s_instr_q   <= NOP_W;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_pc_q      <= m_pc_d;
            m_instr_q   <= m_instr_d;
            s_pc_q      <= s_pc_d;
            s_instr_q   <= s_instr_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = m_pc_q;
    assign out_instr    = m_instr_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_if_ex_skid_stage.sv
// Directed and scoreboard checks for the IF->EX skid stage.
module tb_if_ex_skid_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [15:0] stall_cycles;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_pc;
    logic [31:0] s_in_instr;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_instr;
    logic [3:0]  s_stall;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } beat_t;

    beat_t       q[$];
    logic [15:0] cnt_m;
    logic [31:0] next_pc;
    logic        ov_m;
    logic        ir_m;

    if_ex_skid_stage u_dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .stall_cycles(stall_cycles)
    );

    if_ex_skid_stage #(.CNT_W(4)) u_sat (
        .clock       (clock),
        .reset       (reset),
        .flush       (s_flush),
        .in_valid    (s_in_valid),
        .in_ready    (s_in_ready),
        .in_pc       (s_in_pc),
        .in_instr    (s_in_instr),
        .out_valid   (s_out_valid),
        .out_ready   (s_out_ready),
        .out_pc      (s_out_pc),
        .out_instr   (s_out_instr),
        .stall_cycles(s_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        s_flush = 1'b0;
        s_in_valid = 1'b0;
        s_in_pc = 32'h0;
        s_in_instr = 32'h0;
        s_out_ready = 1'b0;
        #1;
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_ir", 64'(in_ready), 64'd1);
        check("rst_ins", 64'(out_instr), 64'(NOP));
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_cnt", 64'(stall_cycles), 64'd0);
        step();
        reset = 1'b0;

        // streaming
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 32'hA);
        step();
        check("str0_ov", 64'(out_valid), 64'd1);
        check("str0_pc", 64'(out_pc), 64'h0);
        check("str0_in", 64'(out_instr), 64'hA);
        drive(1'b1, 32'h4, 32'hB);
        step();
        check("str1_pc", 64'(out_pc), 64'h4);
        check("str1_in", 64'(out_instr), 64'hB);
        drive(1'b1, 32'h8, 32'hC);
        step();
        check("str2_pc", 64'(out_pc), 64'h8);
        check("str2_in", 64'(out_instr), 64'hC);
        check("str2_ir", 64'(in_ready), 64'd1);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("str3_ov", 64'(out_valid), 64'd0);
        check("str3_in", 64'(out_instr), 64'(NOP));
        check("str3_pc", 64'(out_pc), 64'd0);

        // back-pressure
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 32'h120);
        step();
        check("bp0_pc", 64'(out_pc), 64'h20);
        check("bp0_ir", 64'(in_ready), 64'd1);
        check("bp0_cnt", 64'(stall_cycles), 64'd0);
        drive(1'b1, 32'h24, 32'h124);
        step();
        check("bp1_ir", 64'(in_ready), 64'd0);
        check("bp1_pc", 64'(out_pc), 64'h20);
        check("bp1_cnt", 64'(stall_cycles), 64'd1);
        drive(1'b1, 32'h28, 32'h128);
        step();
        check("bp2_ir", 64'(in_ready), 64'd0);
        check("bp2_pc", 64'(out_pc), 64'h20);
        check("bp2_cnt", 64'(stall_cycles), 64'd2);
        out_ready = 1'b1;
        step();
        check("bp3_pc", 64'(out_pc), 64'h24);
        check("bp3_in", 64'(out_instr), 64'h124);
        check("bp3_ir", 64'(in_ready), 64'd1);
        step();
        check("bp4_pc", 64'(out_pc), 64'h28);
        check("bp4_in", 64'(out_instr), 64'h128);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("bp5_ov", 64'(out_valid), 64'd0);
        check("bp5_cnt", 64'(stall_cycles), 64'd2);

        // flush while full, with a beat offered
        out_ready = 1'b0;
        drive(1'b1, 32'h30, 32'h130);
        step();
        drive(1'b1, 32'h34, 32'h134);
        step();
        check("fl0_ir", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h40, 32'h140);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl1_ov", 64'(out_valid), 64'd0);
        check("fl1_in", 64'(out_instr), 64'(NOP));
        check("fl1_pc", 64'(out_pc), 64'd0);
        check("fl1_ir", 64'(in_ready), 64'd1);
        check("fl1_cnt", 64'(stall_cycles), 64'd3);
        drive(1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        step();
        check("fl2_ov", 64'(out_valid), 64'd0);
        step();
        check("fl3_ov", 64'(out_valid), 64'd0);

        // asynchronous reset while full
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 32'h200);
        step();
        drive(1'b1, 32'h104, 32'h204);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("ar0_ir", 64'(in_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        check("ar_ov", 64'(out_valid), 64'd0);
        check("ar_pc", 64'(out_pc), 64'd0);
        check("ar_in", 64'(out_instr), 64'(NOP));
        check("ar_ir", 64'(in_ready), 64'd1);
        check("ar_cnt", 64'(stall_cycles), 64'd0);
        #1 reset = 1'b0;
        step();
        check("ar1_ov", 64'(out_valid), 64'd0);

        // random traffic vs scoreboard
        q.delete();
        cnt_m = 16'd0;
        next_pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            ov_m = (q.size() != 0);
            ir_m = (q.size() < 2);
            in_valid  = ($urandom % 4) != 0;
            in_pc     = next_pc;
            in_instr  = next_pc ^ 32'h5A5A_0F0F;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 32) == 0;
            if (ov_m && !out_ready && !flush && cnt_m != 16'hFFFF) begin
                cnt_m = cnt_m + 16'd1;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (ov_m && out_ready) begin
                    void'(q.pop_front());
                end
                if (in_valid && ir_m) begin
                    q.push_back({in_pc, in_instr});
                    next_pc = next_pc + 32'd4;
                end
            end
            step();
            check("rnd_ov", 64'(out_valid), 64'(q.size() != 0));
            check("rnd_ir", 64'(in_ready), 64'(q.size() < 2));
            check("rnd_cnt", 64'(stall_cycles), 64'(cnt_m));
            if (q.size() != 0) begin
                check("rnd_pc", 64'(out_pc), 64'(q[0].pc));
                check("rnd_in", 64'(out_instr), 64'(q[0].ins));
            end else begin
                check("rnd_nop", 64'(out_instr), 64'(NOP));
            end
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // counter saturation on the narrow-counter instance
        s_in_valid = 1'b1;
        s_in_pc = 32'h50;
        s_in_instr = 32'h150;
        step();
        s_in_valid = 1'b0;
        check("sat0_ov", 64'(s_out_valid), 64'd1);
        check("sat0_cnt", 64'(s_stall), 64'd0);
        repeat (5) step();
        check("sat5_cnt", 64'(s_stall), 64'd5);
        repeat (15) step();
        check("sat20_cnt", 64'(s_stall), 64'd15);
        check("sat20_pc", 64'(s_out_pc), 64'h50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
